// File: rtl/fp_pkg.sv
// Shared constants, bf16 field layout and FSM encoding for the bfloat16 adder back end.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 8;
    localparam int FRAC_W = MAN_W - 1;
    localparam int BIAS   = 127;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    // Packed bf16 layout: {sign, exponent, fraction}
    localparam int BF16_W   = 1 + EXP_W + FRAC_W;
    localparam int SIGN_POS = BF16_W - 1;
    localparam int EXP_HI   = SIGN_POS - 1;
    localparam int EXP_LO   = FRAC_W;
    localparam int FRAC_HI  = FRAC_W - 1;
    localparam int FRAC_LO  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [BF16_W-1:0] pack_bf16(input logic sign,
                                                    input logic [EXP_W-1:0] exp_f,
                                                    input logic [FRAC_W-1:0] frac);
        logic [BF16_W-1:0] word;
        word                   = '0;
        word[SIGN_POS]         = sign;
        word[EXP_HI:EXP_LO]    = exp_f;
        word[FRAC_HI:FRAC_LO]  = frac;
        return word;
    endfunction

endpackage

// File: rtl/fp_mant_addsub.sv
// Combinational effective add/subtract of two aligned mantissas; yields magnitude and sign.
module fp_mant_addsub
    import fp_pkg::*;
(
    input  logic [MAN_W-1:0] pm,
    input  logic [MAN_W-1:0] qm,
    input  logic             sign_p,
    input  logic             sign_q,
    output logic [MAN_W:0]   mag,
    output logic             sign
);

    logic eff_sub;

    assign eff_sub = sign_p ^ sign_q;

    // Subtraction always yields a non-negative magnitude; the sign follows the larger operand.
    always_comb begin
        mag  = '0;
        sign = sign_p;
        if (!eff_sub) begin
            mag  = {1'b0, pm} + {1'b0, qm};
            sign = sign_p;
        end else if (pm >= qm) begin
            mag  = {1'b0, pm} - {1'b0, qm};
            sign = sign_p;
        end else begin
            mag  = {1'b0, qm} - {1'b0, pm};
            sign = sign_q;
        end
    end

endmodule

// File: rtl/fp_add_normalize.sv
// bf16 adder back end: effective add/sub, iterative one-bit-per-cycle normalisation, packed result.
module fp_add_normalize
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MAN_W-1:0]  pm,
    input  logic [MAN_W-1:0]  qm,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic              sign_p,
    input  logic              sign_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BF16_W-1:0] result
);

    state_t             state, state_n;
    logic [MAN_W-1:0]   p_r, p_n, q_r, q_n, mant_r, mant_n;
    logic [EXP_W-1:0]   exp_r, exp_n;
    logic               sp_r, sp_n, sq_r, sq_n, sign_r, sign_n;
    logic [BF16_W-1:0]  res_r, res_n;

    logic [MAN_W:0]     mag;
    logic               add_sign;
    logic [EXP_W-1:0]   exp_inc, exp_dec;
    logic [MAN_W-1:0]   mant_shl;

    fp_mant_addsub u_addsub (
        .pm     (p_r),
        .qm     (q_r),
        .sign_p (sp_r),
        .sign_q (sq_r),
        .mag    (mag),
        .sign   (add_sign)
    );

    assign exp_inc  = exp_r + 1'b1;
    assign exp_dec  = exp_r - 1'b1;
    assign mant_shl = mant_r << 1;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = res_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            p_r    <= '0;
            q_r    <= '0;
            sp_r   <= 1'b0;
            sq_r   <= 1'b0;
            mant_r <= '0;
            exp_r  <= '0;
            sign_r <= 1'b0;
            res_r  <= '0;
        end else begin
            state  <= state_n;
            p_r    <= p_n;
            q_r    <= q_n;
            sp_r   <= sp_n;
            sq_r   <= sq_n;
            mant_r <= mant_n;
            exp_r  <= exp_n;
            sign_r <= sign_n;
            res_r  <= res_n;
        end
    end

    always_comb begin
        state_n = state;
        p_n     = p_r;
        q_n     = q_r;
        sp_n    = sp_r;
        sq_n    = sq_r;
        mant_n  = mant_r;
        exp_n   = exp_r;
        sign_n  = sign_r;
        res_n   = res_r;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    p_n     = pm;
                    q_n     = qm;
                    sp_n    = sign_p;
                    sq_n    = sign_q;
                    exp_n   = exp_in;
                    state_n = ADD;
                end
            end
            ADD: begin
                sign_n = add_sign;
                if (mag == '0) begin
                    res_n   = '0;
                    state_n = DONE;
                end else if (mag[MAN_W]) begin
                    // Carry out: shift right by one (truncating) and saturate to infinity.
                    if (exp_inc == EXP_MAX)
                        res_n = pack_bf16(add_sign, EXP_MAX, '0);
                    else
                        res_n = pack_bf16(add_sign, exp_inc, mag[MAN_W-1:1]);
                    state_n = DONE;
                end else if (mag[MAN_W-1]) begin
                    res_n   = pack_bf16(add_sign, exp_r, mag[FRAC_W-1:0]);
                    state_n = DONE;
                end else begin
                    mant_n  = mag[MAN_W-1:0];
                    state_n = NORM;
                end
            end
            NORM: begin
                mant_n = mant_shl;
                exp_n  = exp_dec;
                // Hitting exponent zero means the value would be denormal: flush to signed zero.
                if (exp_dec == '0) begin
                    res_n   = pack_bf16(sign_r, '0, '0);
                    state_n = DONE;
                end else if (mant_shl[MAN_W-1]) begin
                    res_n   = pack_bf16(sign_r, exp_dec, mant_shl[FRAC_W-1:0]);
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/fp_add_normalize.md
Name: fp_add_normalize

Overview:
- Downstream stage of the bfloat16 adder; sits directly after mantissa alignment.
- Takes two aligned 8-bit mantissas (hidden 1 at bit 7), the larger exponent and both signs.
- Performs the effective add or subtract, then normalises iteratively with one left shift per cycle.
- Returns a packed bf16 result over a valid/ready handshake.

Parameters:
- EXP_W, 8, exponent width
- MAN_W, 8, aligned mantissa width including hidden bit (stored fraction = MAN_W-1)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept (high only in IDLE)
- pm  input  8  mantissa of larger-exponent operand, hidden bit included
- qm  input  8  aligned (right-shifted) mantissa of other operand
- exp_in  input  8  larger exponent
- sign_p  input  1  sign of pm operand
- sign_q  input  1  sign of qm operand
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  16  {sign, exp[7:0], frac[6:0]}

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: state=IDLE, in_ready=1, out_valid=0, result=16'h0000, all internal registers 0. Asserting rst_n low mid-operation aborts the operation and discards it; no partial result is emitted.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, register the operands and go to ADD.
  - ADD (1 cycle): eff_sub = sign_p^sign_q. Produce a 9-bit value:
    - Add: sum = pm+qm, sign = sign_p.
    - Subtract, pm>=qm: sum = pm-qm, sign = sign_p.
    - Subtract, pm<qm: sum = qm-pm, sign = sign_q.
  - ADD outcomes:
    - sum==0: result=16'h0000 (always +0), go to DONE.
    - sum[8]=1: mant = sum[8:1] (truncate), exp+1. If exp+1==255, result = {sign, 8'hFF, 7'h00} (infinity). Go to DONE.
    - sum[7]=1: result = {sign, exp, sum[6:0]}, go to DONE.
    - Otherwise go to NORM.
  - NORM: each cycle, mant<<=1 and exp-=1.
    - Once mant[7]=1, result = {sign, exp, mant[6:0]}, go to DONE.
    - If exp would reach 0 before mant[7] is set, flush: result={sign,15'h0}, go to DONE. Denormals are not supported.
    - At most 7 shifts.
- DONE: out_valid=1; result is held stable. On out_ready, deassert out_valid and go to IDLE; in_ready rises the next cycle. No accept in the same cycle as a DONE handshake.
- Latency: out_valid rises 2 cycles after acceptance, plus 1 cycle per normalisation shift (max 9).
- Rounding: truncation only.
- exp_in==0 or 255 inputs: not special-cased; upstream guarantees finite normal operands.

Decomposition:
- Shared package fp_pkg:
  - EXP_W, MAN_W, BIAS=127
  - EXP_MAX=8'hFF
  - packed bf16 field positions
  - FSM state encoding IDLE/ADD/NORM/DONE.
- One natural sub-module: fp_mant_addsub, purely combinational. Outputs the 9-bit magnitude and the result sign from pm, qm, sign_p, sign_q. Reused by the subtractor path.
- Shift, exponent counter and FSM stay in the top module.

Test Plan:
- 1.0+1.0: pm=8'h80, qm=8'h80, exp_in=127, signs 0/0 -> result 16'h4000, out_valid 2 cycles after accept.
- 1.5-1.0: pm=8'hC0, qm=8'h80, exp_in=127, signs 0/1 -> one NORM shift, result 16'h3F00 at 3 cycles.
- Negative swap: pm=8'h80, qm=8'hC0, exp_in=127, signs 0/1 -> result 16'hBF00 (-0.5).
- Cancellation and overflow:
  - pm=qm=8'hA0, signs 0/1 -> result 16'h0000.
  - pm=qm=8'h80, exp_in=254, signs 0/0 -> result 16'h7F80 (+inf).
- Deep normalisation and flush:
  - pm=8'h81, qm=8'h80, exp_in=127, signs 0/1 -> 7 shifts, result 16'h3C00, latency 9.
  - Same operands with exp_in=3 -> result 16'h0000.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles -> result stable, in_ready=0, no new accept.
  - Drop rst_n during NORM -> out_valid=0, in_ready=1 immediately, and the next operation is correct.
